// File: rtl/cache_line_writeback.sv
// Dirty-line write-back engine: captures a full cache line and its aligned base address,
// then streams the words to memory lowest-first over a valid/ack handshake.
module cache_line_writeback #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                start,
  input  logic [WORD_SIZE-1:0]                line_addr_i,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_data_i,
  output logic                                mem_we_o,
  output logic [WORD_SIZE-1:0]                mem_addr_o,
  output logic [WORD_SIZE-1:0]                mem_data_o,
  input  logic                                mem_ack_i,
  output logic                                busy,
  output logic                                done
);

  localparam int LINE_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS  = LINE_BITS + 2;
  localparam logic [LINE_BITS-1:0] LAST_WORD = LINE_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                                    state;
  logic [LINE_BITS-1:0]                      cnt;
  logic [WORD_SIZE-1:0]                      base;
  logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0]  buffer;
  logic                                      we_r;
  logic                                      busy_r;
  logic                                      done_r;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      base   <= '0;
      buffer <= '0;
      we_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Base is line-aligned, so word offsets never carry out of the line.
            base   <= {line_addr_i[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
            buffer <= line_data_i;
            cnt    <= '0;
            we_r   <= 1'b1;
            busy_r <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            if (cnt == LAST_WORD) begin
              we_r   <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          cnt    <= '0;
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          cnt    <= '0;
          we_r   <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign mem_we_o   = we_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign mem_addr_o = base + WORD_SIZE'({cnt, 2'b00});
  assign mem_data_o = buffer[cnt];

endmodule
